empipe_skid: RTL and testbench
==============================

Name: empipe_skid

Overview:
- Parametrised execute-to-memory pipeline register, the successor to the fixed-width E/M stage.
- Carries the regw, memw and regmem control bits plus the destination register index, ALU result and memory address from E to M.
- Adds a valid/ready handshake with a one-entry skid buffer, so the memory stage can stall without a combinational ready path back into execute.
- Adds a synchronous flush that converts in-flight instructions into bubbles.

Parameters:
DATA_W, 32, width of the ALU result path
ADDR_W, 32, width of the memory address path
REG_W, 4, width of the destination register index

Ports:
clk  in  1  clock; every register samples on the rising edge
rst  in  1  reset, synchronous, active-low
flush  in  1  synchronous pipeline flush
valid_E  in  1  the E-side fields hold an instruction
ready_E  out  1  the stage can accept an instruction this cycle (driven from a register)
regw_E  in  1  register-write enable
memw_E  in  1  memory-write enable
regmem_E  in  1  writeback-select (memory vs ALU)
regScr_E  in  REG_W  destination register index
ALUrslt_E  in  DATA_W  ALU result
address_E  in  ADDR_W  memory address
valid_M  out  1  the M-side fields hold an instruction
ready_M  in  1  the memory stage consumes the output this cycle
regw_M, memw_M, regmem_M  out  1 each  gated control bits
regScr_M  out  REG_W  destination register index
ALUrslt_M  out  DATA_W  ALU result
address_M  out  ADDR_W  memory address

Behaviour:
- Handshakes:
  - Accept occurs when valid_E && ready_E.
  - Consume occurs when valid_M && ready_M.
- Storage: a main (output) entry and a skid entry. State is derived from the two valid bits:
  - EMPTY: neither entry valid.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- State transitions, evaluated each rising edge:
  - EMPTY: accept -> load main, go to ONE; otherwise stay.
  - ONE:
    - accept and consume -> main <= input, stay in ONE.
    - accept only -> skid <= input, go to FULL.
    - consume only -> go to EMPTY.
    - neither -> hold.
  - FULL: ready_E=0, so there is no accept.
    - consume -> main <= skid, skid invalid, go to ONE.
    - otherwise hold.
- ready_E is registered. Next value = 1 unless the next state is FULL.
- Ordering and timing:
  - Strict in-order delivery; no instruction is lost or duplicated.
  - Latency: accept at edge N gives valid_M=1 after edge N, when the stage was EMPTY or when ONE with a simultaneous consume.
  - Throughput: 1 instruction/cycle while ready_M=1.
- Control gating: regw_M, memw_M and regmem_M are forced to 0 whenever valid_M=0. A bubble never writes the register file or memory.
- Data hold: regScr_M, ALUrslt_M and address_M keep their last loaded values when main is invalid. They are never X after reset.
- Flush:
  - flush=1 at an edge (with rst=1) -> both entries invalid, state EMPTY, ready_E=1.
  - An accept in the same cycle is discarded.
  - A consume in the same cycle is still counted by the consumer.
- Reset (rst=0 at an edge):
  - valid_M=0 and the skid entry is invalid.
  - All M outputs = 0 and ready_E=1.
  - Reset dominates flush and any handshake in that cycle.
  - Reset mid-stall (FULL) drops both entries.
- Stability: while valid_M=1 and ready_M=0, every M output holds steady across cycles.
- Width: fields pass through unmodified; no sign or zero extension.

Test Plan:
- Reset then passthrough: rst=0 for 2 edges -> all M outputs 0 and ready_E=1. With ready_M=1, present valid_E=1, regw=1, regScr=4'b0011, ALUrslt=32'h0000FFFF, address=32'h00010004 -> the same fields appear with valid_M=1 one edge later.
- Back-to-back stream: 4 instructions with regScr=1..4 on consecutive cycles, ready_M=1 -> valid_M high for 4 consecutive cycles, regScr_M=1,2,3,4 in order, ready_E stays 1.
- Stall into skid: ready_M=0 after the first accept, second instruction (regScr=4'b0100) offered -> accepted into skid, ready_E=0 the next cycle, regScr_M holds 4'b0011. Raise ready_M -> 4'b0011 then 4'b0100 delivered, ready_E back to 1.
- Flush: stage FULL with memw=1 entries, assert flush for 1 cycle -> valid_M=0, memw_M=0, ready_E=1 next cycle. An instruction offered during the flush cycle never appears.
- Reset mid-operation: FULL with ready_M=0, assert rst=0 for 1 edge -> valid_M=0, outputs 0, ready_E=1. New instruction ALUrslt=32'h12345678 flows normally afterwards.
- Bubble gating: valid_E=0 with regw_E=1 and memw_E=1 held for 3 cycles -> valid_M=0 and regw_M=memw_M=0 throughout.

Source files
------------

// File: rtl/empipe_skid.sv
// Execute-to-memory pipeline register with valid/ready handshake and a one-entry skid buffer.
// ready_E is registered, so a memory-stage stall never forms a combinational path back into execute.
module empipe_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_E,
  output logic              ready_E,
  input  logic              regw_E,
  input  logic              memw_E,
  input  logic              regmem_E,
  input  logic [REG_W-1:0]  regScr_E,
  input  logic [DATA_W-1:0] ALUrslt_E,
  input  logic [ADDR_W-1:0] address_E,
  output logic              valid_M,
  input  logic              ready_M,
  output logic              regw_M,
  output logic              memw_M,
  output logic              regmem_M,
  output logic [REG_W-1:0]  regScr_M,
  output logic [DATA_W-1:0] ALUrslt_M,
  output logic [ADDR_W-1:0] address_M
);

  localparam int PW = 3 + REG_W + DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  logic [PW-1:0] in_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_vld;
  logic          skid_vld;
  logic          rdy_q;
  logic          accept;
  logic          consume;
  logic          m_regw;
  logic          m_memw;
  logic          m_regmem;
  state_t        state;

  assign in_d    = {regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E};
  assign state   = state_t'({skid_vld, main_vld});
  assign accept  = valid_E & rdy_q;
  assign consume = main_vld & ready_M;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (flush) begin
      // Payload registers keep their contents; only the valid bits are dropped.
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q   <= in_d;
            main_vld <= 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_q <= in_d;
          end else if (accept) begin
            skid_q   <= in_d;
            skid_vld <= 1'b1;
            rdy_q    <= 1'b0;
          end else if (consume) begin
            main_vld <= 1'b0;
          end
        end
        FULL: begin
          if (consume) begin
            main_q   <= skid_q;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
          end
        end
        default: begin
          main_vld <= 1'b0;
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign {m_regw, m_memw, m_regmem, regScr_M, ALUrslt_M, address_M} = main_q;

  // A bubble must never write the register file or memory.
  assign regw_M   = m_regw & main_vld;
  assign memw_M   = m_memw & main_vld;
  assign regmem_M = m_regmem & main_vld;
  assign valid_M  = main_vld;
  assign ready_E  = rdy_q;

endmodule

// File: tb/tb_empipe_skid.sv
// Directed and randomized bench for empipe_skid against a queue-based reference model.
module tb_empipe_skid;

  typedef struct packed {
    logic        regw;
    logic        memw;
    logic        regmem;
    logic [3:0]  scr;
    logic [31:0] alu;
    logic [31:0] addr;
  } item_t;

  logic        clk = 1'b0;
  logic        rst, flush, valid_E, ready_E, regw_E, memw_E, regmem_E;
  logic [3:0]  regScr_E, regScr_M;
  logic [31:0] ALUrslt_E, address_E, ALUrslt_M, address_M;
  logic        valid_M, ready_M, regw_M, memw_M, regmem_M;

  int n_cmp = 0;
  int n_err = 0;

  item_t q[$];
  item_t last_main = '0;

  empipe_skid #(.DATA_W(32), .ADDR_W(32), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_E(valid_E), .ready_E(ready_E),
    .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E),
    .regScr_E(regScr_E), .ALUrslt_E(ALUrslt_E), .address_E(address_E),
    .valid_M(valid_M), .ready_M(ready_M),
    .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .address_M(address_M)
  );

  always #5 clk = ~clk;

  // Reference: an ordered queue of at most two instructions.
  always @(posedge clk) begin
    bit cons, acc;
    if (!rst) begin
      q.delete();
      last_main = '0;
    end else begin
      cons = (q.size() > 0) && ready_M;
      acc  = valid_E && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back({regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E});
      end
      if (q.size() > 0) last_main = q[0];
    end
  end

  function automatic item_t exp_item();
    return (q.size() > 0) ? q[0] : last_main;
  endfunction

  task automatic drive(input logic v, input item_t it, input logic rm, input logic fl);
    valid_E   = v;
    regw_E    = it.regw;
    memw_E    = it.memw;
    regmem_E  = it.regmem;
    regScr_E  = it.scr;
    ALUrslt_E = it.alu;
    address_E = it.addr;
    ready_M   = rm;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic item_t mk(input logic rw, input logic mw, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] ad);
    item_t it;
    it.regw = rw; it.memw = mw; it.regmem = 1'b0; it.scr = s; it.alu = a; it.addr = ad;
    return it;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, mk(1'b1, 1'b1, 4'hA, 32'hDEAD_BEEF, 32'hCAFE_0000), 1'b1, 1'b1);
    tick(); tick();
    n_cmp++;
    if ({valid_M, regw_M, memw_M, regmem_M} !== 4'b0000 || regScr_M !== 4'h0 ||
        ALUrslt_M !== 32'h0 || address_M !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got vld=%b ctl=%b%b%b scr=%h alu=%h addr=%h, want all 0",
               valid_M, regw_M, memw_M, regmem_M, regScr_M, ALUrslt_M, address_M);
    end
    n_cmp++;
    if (ready_E !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", ready_E);
    end
  endtask

  task automatic test_passthrough();
    rst = 1'b1;
    drive(1'b1, mk(1'b1, 1'b0, 4'b0011, 32'h0000_FFFF, 32'h0001_0004), 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (valid_M !== 1'b1 || regw_M !== 1'b1 || memw_M !== 1'b0 || regScr_M !== 4'b0011 ||
        ALUrslt_M !== 32'h0000_FFFF || address_M !== 32'h0001_0004) begin
      n_err++;
      $display("FAIL passthrough: got vld=%b rw=%b mw=%b scr=%h alu=%h addr=%h, want 1 1 0 3 0000ffff 00010004",
               valid_M, regw_M, memw_M, regScr_M, ALUrslt_M, address_M);
    end
    tick();
    n_cmp++;
    if (valid_M !== 1'b0 || regw_M !== 1'b0 || ALUrslt_M !== 32'h0000_FFFF) begin
      n_err++;
      $display("FAIL passthrough_drain: got vld=%b rw=%b alu=%h, want 0 0 0000ffff (held)",
               valid_M, regw_M, ALUrslt_M);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(1'b0, 1'b0, 4'(i), 32'(i * 16), 32'(i)), 1'b1, 1'b0);
      tick();
      n_cmp++;
      if (valid_M !== 1'b1 || regScr_M !== 4'(i) || ready_E !== 1'b1) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got vld=%b scr=%h rdy=%b, want 1 %h 1",
                 i, valid_M, regScr_M, ready_E, 4'(i));
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (valid_M !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back_end: got vld=%b want 0", valid_M);
    end
  endtask

  task automatic test_stall_skid();
    drive(1'b1, mk(1'b1, 1'b0, 4'b0011, 32'h1, 32'h2), 1'b1, 1'b0);
    tick();
    drive(1'b1, mk(1'b1, 1'b0, 4'b0100, 32'h3, 32'h4), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (ready_E !== 1'b0 || valid_M !== 1'b1 || regScr_M !== 4'b0011) begin
      n_err++;
      $display("FAIL stall_full: got rdy=%b vld=%b scr=%h, want 0 1 3", ready_E, valid_M, regScr_M);
    end
    tick();
    n_cmp++;
    if (regScr_M !== 4'b0011 || ALUrslt_M !== 32'h1 || valid_M !== 1'b1) begin
      n_err++;
      $display("FAIL stall_hold: got scr=%h alu=%h vld=%b, want 3 1 1", regScr_M, ALUrslt_M, valid_M);
    end
    ready_M = 1'b1;
    tick();
    n_cmp++;
    if (valid_M !== 1'b1 || regScr_M !== 4'b0100 || ready_E !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got vld=%b scr=%h rdy=%b, want 1 4 1", valid_M, regScr_M, ready_E);
    end
    tick();
    n_cmp++;
    if (valid_M !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain: got vld=%b want 0", valid_M);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, mk(1'b0, 1'b1, 4'h5, 32'h55, 32'h500), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(1'b0, 1'b1, 4'h6, 32'h66, 32'h600), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(1'b0, 1'b1, 4'hF, 32'hFF, 32'hF00), 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (valid_M !== 1'b0 || memw_M !== 1'b0 || ready_E !== 1'b1) begin
      n_err++;
      $display("FAIL flush_full: got vld=%b mw=%b rdy=%b, want 0 0 1", valid_M, memw_M, ready_E);
    end
    // One entry held, a new instruction offered while flushing must be discarded.
    drive(1'b1, mk(1'b0, 1'b1, 4'h7, 32'h77, 32'h700), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(1'b0, 1'b1, 4'hE, 32'hEE, 32'hE00), 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (valid_M !== 1'b0 || memw_M !== 1'b0) begin
        n_err++;
        $display("FAIL flush_discard[%0d]: got vld=%b mw=%b scr=%h, want vld 0 mw 0", i, valid_M, memw_M, regScr_M);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, mk(1'b1, 1'b1, 4'h8, 32'h88, 32'h800), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(1'b1, 1'b1, 4'h9, 32'h99, 32'h900), 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, mk(1'b1, 1'b1, 4'hA, 32'hAA, 32'hA00), 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, mk(1'b1, 1'b0, 4'h2, 32'h1234_5678, 32'h40), 1'b1, 1'b0);
    n_cmp++;
    if ({valid_M, regw_M, memw_M, regmem_M} !== 4'b0000 || regScr_M !== 4'h0 ||
        ALUrslt_M !== 32'h0 || address_M !== 32'h0 || ready_E !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: got vld=%b scr=%h alu=%h addr=%h rdy=%b, want 0 0 0 0 1",
               valid_M, regScr_M, ALUrslt_M, address_M, ready_E);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (valid_M !== 1'b1 || ALUrslt_M !== 32'h1234_5678 || regScr_M !== 4'h2) begin
      n_err++;
      $display("FAIL reset_mid_resume: got vld=%b alu=%h scr=%h, want 1 12345678 2", valid_M, ALUrslt_M, regScr_M);
    end
    tick();
  endtask

  task automatic test_bubble_gating();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, mk(1'b1, 1'b1, 4'hC, 32'hC, 32'hC), 1'($urandom_range(0, 1)), 1'b0);
      regmem_E = 1'b1;
      tick();
      n_cmp++;
      if (valid_M !== 1'b0 || regw_M !== 1'b0 || memw_M !== 1'b0 || regmem_M !== 1'b0) begin
        n_err++;
        $display("FAIL bubble[%0d]: got vld=%b rw=%b mw=%b rm=%b, want 0 0 0 0", i, valid_M, regw_M, memw_M, regmem_M);
      end
    end
  endtask

  task automatic test_random();
    item_t it, e;
    bit ev;
    for (int c = 0; c < 600; c++) begin
      it = item_t'({$urandom, $urandom, $urandom});
      rst = ($urandom_range(0, 63) != 0);
      drive(1'($urandom_range(0, 3) != 0), it, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      tick();
      e  = exp_item();
      ev = (q.size() > 0);
      n_cmp++;
      if (valid_M !== ev || ready_E !== (q.size() < 2) ||
          regw_M !== (ev & e.regw) || memw_M !== (ev & e.memw) || regmem_M !== (ev & e.regmem) ||
          regScr_M !== e.scr || ALUrslt_M !== e.alu || address_M !== e.addr) begin
        n_err++;
        $display("FAIL random[%0d]: got vld=%b rdy=%b ctl=%b%b%b scr=%h alu=%h addr=%h, want vld=%b rdy=%b ctl=%b%b%b scr=%h alu=%h addr=%h",
                 c, valid_M, ready_E, regw_M, memw_M, regmem_M, regScr_M, ALUrslt_M, address_M,
                 ev, (q.size() < 2), ev & e.regw, ev & e.memw, ev & e.regmem, e.scr, e.alu, e.addr);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_stall_skid();
    test_flush();
    test_reset_mid();
    test_bubble_gating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
